// File: rtl/outbuf_user_reader.sv
// User-side drain engine: pops one parity word from the output buffer and
// streams it out MSB-first as USER_BUS_W-wide valid/ready beats.
module outbuf_user_reader #(
  parameter int PACKET_LENGTH          = 2,
  parameter int W                      = 4,
  parameter int PCK_TREE_XOR_UNITS_NUM = 6,
  parameter int OUTBUF_DATA_W          = PACKET_LENGTH * W * PCK_TREE_XOR_UNITS_NUM,
  parameter int USER_BUS_W             = 8,
  parameter int CNT_W                  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     drain_en,
  input  logic                     outbuf_fifo_cntl_empty,
  output logic                     user_outbuf_rd_req,
  input  logic                     outbuf_user_rd_ack,
  input  logic                     outbuf_dout_reg_val,
  input  logic [OUTBUF_DATA_W-1:0] outbuf_dout_reg,
  output logic                     user_dout_valid,
  output logic [USER_BUS_W-1:0]    user_dout,
  output logic                     user_dout_last,
  input  logic                     user_dout_ready,
  output logic                     busy,
  output logic [CNT_W-1:0]         words_drained,
  output logic                     protocol_err
);

  localparam int BEATS = OUTBUF_DATA_W / USER_BUS_W;
  localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);

  generate
    if ((OUTBUF_DATA_W % USER_BUS_W) != 0) begin : g_width_chk
      $error("OUTBUF_DATA_W must be a multiple of USER_BUS_W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, SEND} state_t;

  state_t                   state, state_nxt;
  logic [OUTBUF_DATA_W-1:0] sreg;
  logic [BC_W-1:0]          beat_cnt;
  logic                     capture, beat_fire, word_done, stray_val;

  always_comb begin
    state_nxt          = state;
    user_outbuf_rd_req = 1'b0;
    user_dout_valid    = 1'b0;
    capture            = 1'b0;
    beat_fire          = 1'b0;
    word_done          = 1'b0;
    stray_val          = 1'b0;
    case (state)
      IDLE: begin
        stray_val = outbuf_dout_reg_val;
        if (drain_en && !outbuf_fifo_cntl_empty) state_nxt = REQ;
      end
      REQ: begin
        user_outbuf_rd_req = 1'b1;
        // Data may ride along with the ack; only then is val legal in REQ.
        if (outbuf_user_rd_ack) begin
          if (outbuf_dout_reg_val) begin
            capture   = 1'b1;
            state_nxt = SEND;
          end else begin
            state_nxt = WAIT_DATA;
          end
        end else begin
          stray_val = outbuf_dout_reg_val;
        end
      end
      WAIT_DATA: begin
        if (outbuf_dout_reg_val) begin
          capture   = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        user_dout_valid = 1'b1;
        stray_val       = outbuf_dout_reg_val;
        if (user_dout_ready) begin
          beat_fire = 1'b1;
          if (beat_cnt == LAST_BEAT) begin
            word_done = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign user_dout      = (state == SEND) ? sreg[OUTBUF_DATA_W-1 -: USER_BUS_W] : '0;
  assign user_dout_last = (state == SEND) && (beat_cnt == LAST_BEAT);
  assign busy           = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sreg          <= '0;
      beat_cnt      <= '0;
      words_drained <= '0;
      protocol_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        sreg     <= outbuf_dout_reg;
        beat_cnt <= '0;
      end else if (beat_fire) begin
        sreg     <= sreg << USER_BUS_W;
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (word_done) words_drained <= words_drained + 1'b1;
      if (stray_val) protocol_err  <= 1'b1;
    end
  end

endmodule
